// File: rtl/intr_gen_mc.sv
// Multi-channel interrupt stimulus generator.
// Each channel counts down a programmable interval, with optional jitter
// taken from a shared LFSR. On expiry it raises a level or pulse interrupt.
// The block also counts overruns per channel and the total number of expiries.
module intr_gen_mc #(
  parameter int          NumCh    = 3,
  parameter int          CntW     = 16,
  parameter logic [31:0] LfsrSeed = 32'h1234_5678
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [4*NumCh-1:0]   intvl_i,
  input  logic [NumCh-1:0]     mode_i,
  input  logic                 jitter_en_i,
  input  logic [NumCh-1:0]     ack_i,
  output logic [NumCh-1:0]     irq_o,
  output logic [8*NumCh-1:0]   lost_cnt_o,
  output logic [15:0]          total_fire_cnt_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_ASSERT} ch_state_e;

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  // Interval code scaled by 16 plus optional jitter nibble, zero-extended.
  function automatic logic [CntW-1:0] reload_val(input logic [3:0] intvl,
                                                 input logic [3:0] jit,
                                                 input logic       jit_en);
    logic [7:0] l;
    l = {intvl, 4'b0000} + (jit_en ? {4'b0000, jit} : 8'd0);
    return {{(CntW-8){1'b0}}, l};
  endfunction

  // Overrun counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] popcount(input logic [NumCh-1:0] v);
    logic [15:0] n;
    n = 16'd0;
    for (int i = 0; i < NumCh; i++) n = n + 16'(v[i]);
    return n;
  endfunction

  ch_state_e          state_q [NumCh];
  ch_state_e          state_d [NumCh];
  logic [CntW-1:0]    cnt_q   [NumCh];
  logic [CntW-1:0]    cnt_d   [NumCh];
  logic [7:0]         lost_q  [NumCh];
  logic [7:0]         lost_d  [NumCh];
  logic [NumCh-1:0]   mode_q, mode_d;
  logic [NumCh-1:0]   irq_q, irq_d;
  logic [NumCh-1:0]   expiry;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [15:0]        total_q;
  logic [3:0]         intvl_c;
  logic [CntW-1:0]    reload_c;
  logic               active_c;

  // Next-state logic: LFSR step plus the per-channel IDLE/COUNT/ASSERT machine.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
    expiry   = '0;
    mode_d   = mode_q;
    irq_d    = irq_q;
    intvl_c  = '0;
    reload_c = '0;
    active_c = 1'b0;
    for (int c = 0; c < NumCh; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      lost_d[c]  = lost_q[c];
      intvl_c    = intvl_i[4*c +: 4];
      reload_c   = reload_val(intvl_c, lfsr_q[4*c +: 4], jitter_en_i);
      active_c   = en_i && (intvl_c != 4'd0);
      unique case (state_q[c])
        ST_IDLE: begin
          if (active_c) begin
            cnt_d[c]   = reload_c;
            mode_d[c]  = mode_i[c];
            state_d[c] = ST_COUNT;
          end
        end
        ST_COUNT, ST_ASSERT: begin
          if (!active_c) begin
            // Disable wins over a coincident expiry.
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
            irq_d[c]   = 1'b0;
          end else if (cnt_q[c] == '0) begin
            expiry[c]  = 1'b1;
            cnt_d[c]   = reload_c;
            mode_d[c]  = mode_i[c];
            irq_d[c]   = 1'b1;
            if (state_q[c] == ST_ASSERT) begin
              // irq is always high in ASSERT; an unacked expiry is an overrun.
              if (!ack_i[c]) lost_d[c] = sat_inc8(lost_q[c]);
            end else if (!mode_q[c]) begin
              state_d[c] = ST_ASSERT;
            end
          end else begin
            cnt_d[c] = cnt_q[c] - CntW'(1);
            if (state_q[c] == ST_COUNT) begin
              irq_d[c] = 1'b0;
            end else if (ack_i[c]) begin
              irq_d[c]   = 1'b0;
              state_d[c] = ST_COUNT;
            end
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  // State, counter and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q  <= LfsrSeed;
      mode_q  <= '0;
      irq_q   <= '0;
      total_q <= '0;
      for (int c = 0; c < NumCh; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
        lost_q[c]  <= '0;
      end
    end else begin
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      irq_q   <= irq_d;
      total_q <= total_q + popcount(expiry);
      for (int c = 0; c < NumCh; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        lost_q[c]  <= lost_d[c];
      end
    end
  end

  // Pack the per-channel overrun counters onto the output bus.
  always_comb begin
    lost_cnt_o = '0;
    for (int c = 0; c < NumCh; c++) lost_cnt_o[8*c +: 8] = lost_q[c];
  end

  assign irq_o            = irq_q;
  assign total_fire_cnt_o = total_q;

endmodule

// File: tb/tb_intr_gen_mc.sv
// Bench for intr_gen_mc: directed scenarios followed by randomized traffic.
// A reference model tracks absolute expiry times per channel.
module tb_intr_gen_mc;

  localparam logic [31:0] Seed = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n, en, jit;
  logic [11:0] intvl;
  logic [2:0]  mode, ack;
  logic [2:0]  irq;
  logic [23:0] lost;
  logic [15:0] total;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_run  [3];
  longint      m_next [3];
  bit          m_mode [3];
  logic [2:0]  m_irq;
  int          m_lost [3];
  int          m_total;
  logic [31:0] m_lfsr;
  longint      e = 0;
  int          m_nib0 = 0;

  intr_gen_mc #(.NumCh(3), .CntW(16), .LfsrSeed(Seed)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .en_i             (en),
    .intvl_i          (intvl),
    .mode_i           (mode),
    .jitter_en_i      (jit),
    .ack_i            (ack),
    .irq_o            (irq),
    .lost_cnt_o       (lost),
    .total_fire_cnt_o (total)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int fired;
    int iv;
    int len;
    bit act;
    e++;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        m_run[c] = 0; m_lost[c] = 0; m_mode[c] = 0;
      end
      m_irq   = '0;
      m_total = 0;
      m_lfsr  = Seed;
      return;
    end
    fired = 0;
    for (int c = 0; c < 3; c++) begin
      iv  = int'(intvl[4*c +: 4]);
      act = en && (iv != 0);
      len = iv * 16 + (jit ? int'(m_lfsr[4*c +: 4]) : 0);
      if (!m_run[c]) begin
        if (act) begin
          m_run[c] = 1; m_next[c] = e + len + 1; m_mode[c] = mode[c];
        end
      end else if (!act) begin
        m_run[c] = 0; m_irq[c] = 1'b0;
      end else if (e == m_next[c]) begin
        fired++;
        if (!m_mode[c] && m_irq[c] && !ack[c] && m_lost[c] < 255) m_lost[c]++;
        m_irq[c]  = 1'b1;
        m_next[c] = e + len + 1;
        m_mode[c] = mode[c];
        if (c == 0) m_nib0 = jit ? int'(m_lfsr[3:0]) : 0;
      end else if (m_mode[c] || ack[c]) begin
        m_irq[c] = 1'b0;
      end
    end
    m_total = (m_total + fired) % 65536;
    m_lfsr  = lfsr_step(m_lfsr);
  endtask

  task automatic check_model();
    logic [23:0] pk;
    for (int c = 0; c < 3; c++) pk[8*c +: 8] = 8'(m_lost[c]);
    chk("model_irq", 32'(irq), 32'(m_irq));
    chk("model_lost", 32'(lost), 32'(pk));
    chk("model_total", 32'(total), 32'(m_total));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int rise [3];
    int k;
    int g;
    int ch;
    rst_n = 1'b0; en = 1'b0; intvl = '0; mode = '0; jit = 1'b0; ack = '0;
    tick(); tick();
    chk("reset_irq", 32'(irq), 0);
    chk("reset_lost", 32'(lost), 0);
    chk("reset_total", 32'(total), 0);

    // Level mode ch0, interval 16, no ack: rise at load+17, overrun at +34
    rst_n = 1'b1; en = 1'b1; intvl = 12'h001;
    tick();
    repeat (16) tick();
    chk("s1_before_rise", 32'(irq[0]), 0);
    tick();
    chk("s1_rise", 32'(irq[0]), 1);
    repeat (17) tick();
    chk("s1_lost", 32'(lost[7:0]), 1);
    chk("s1_total", 32'(total), 2);
    chk("s1_irq_held", 32'(irq[0]), 1);

    // Disable, then ch1 pulse mode interval 32
    en = 1'b0;
    tick();
    chk("s2_disable_irq", 32'(irq), 0);
    chk("s2_lost_held", 32'(lost[7:0]), 1);
    en = 1'b1; intvl = 12'h020; mode = 3'b010;
    tick();
    for (int p = 1; p <= 3; p++) begin
      repeat (p == 1 ? 32 : 31) tick();
      chk("s2_pulse_pre", 32'(irq[1]), 0);
      tick();
      chk("s2_pulse", 32'(irq[1]), 1);
      chk("s2_total", 32'(total), 32'(2 + p));
      tick();
      chk("s2_pulse_end", 32'(irq[1]), 0);
    end
    chk("s2_lost1", 32'(lost[15:8]), 0);

    // Ack handshake on ch0 level mode
    en = 1'b0; mode = 3'b000;
    tick();
    en = 1'b1; intvl = 12'h001;
    tick();
    repeat (17) tick();
    chk("s3_rise", 32'(irq[0]), 1);
    ack = 3'b001; tick(); ack = 3'b000;
    chk("s3_ack_clear", 32'(irq[0]), 0);
    repeat (15) tick();
    chk("s3_pre_rise2", 32'(irq[0]), 0);
    tick();
    chk("s3_rise2", 32'(irq[0]), 1);
    repeat (16) tick();
    ack = 3'b001; tick(); ack = 3'b000;
    chk("s3_ack_on_expiry_irq", 32'(irq[0]), 1);
    chk("s3_ack_on_expiry_lost", 32'(lost[7:0]), 1);

    // All channels enabled together
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    intvl = 12'h111; mode = 3'b000; en = 1'b1;
    tick();
    repeat (16) tick();
    chk("s4_pre_irq", 32'(irq), 0);
    chk("s4_pre_total", 32'(total), 0);
    tick();
    chk("s4_irq_all", 32'(irq), 32'h7);
    chk("s4_total3", 32'(total), 3);

    // Reset while asserted with accumulated overruns
    repeat (85) tick();
    chk("s5_lost5", 32'(lost[7:0]), 5);
    chk("s5_irq", 32'(irq[0]), 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("s5_rst_irq", 32'(irq), 0);
    chk("s5_rst_lost", 32'(lost), 0);
    chk("s5_rst_total", 32'(total), 0);

    // en_i low mid-period stops everything
    intvl = 12'h001;
    tick();
    repeat (17) tick();
    chk("s6_rise", 32'(irq[0]), 1);
    repeat (5) tick();
    en = 1'b0;
    tick();
    chk("s6_dis_irq", 32'(irq), 0);
    repeat (40) tick();
    chk("s6_no_fire", 32'(total), 1);
    chk("s6_irq_low", 32'(irq), 0);

    // Jitter: first load after reset uses the seed nibbles 8,7,6
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    en = 1'b1; intvl = 12'h111; jit = 1'b1; mode = 3'b000;
    tick();
    for (int c = 0; c < 3; c++) rise[c] = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      for (int c = 0; c < 3; c++) if (irq[c] && rise[c] == 0) rise[c] = i;
    end
    chk("jit_first0", 32'(rise[0]), 25);
    chk("jit_first1", 32'(rise[1]), 24);
    chk("jit_first2", 32'(rise[2]), 23);
    ack = 3'b001; tick(); ack = 3'b000;
    k = 0;
    while (!irq[0] && k < 40) begin tick(); k++; end
    chk("jit_wait", 32'(irq[0]), 1);
    for (int p = 0; p < 4; p++) begin
      g = 17 + m_nib0;
      ack = 3'b001; tick(); ack = 3'b000;
      k = 1;
      while (!irq[0] && k < 40) begin tick(); k++; end
      chk("jit_gap", 32'(k), 32'(g));
      chk("jit_range", 32'(k >= 17 && k <= 32), 1);
    end

    // Overrun counter saturation
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    jit = 1'b0; intvl = 12'h001; en = 1'b1; ack = '0;
    tick();
    repeat (4400) tick();
    chk("sat_lost", 32'(lost[7:0]), 32'hFF);
    chk("sat_irq", 32'(irq[0]), 1);

    // Randomized traffic; mode only changes while disabled
    for (int seg = 0; seg < 8; seg++) begin
      en = 1'b0; ack = '0;
      tick();
      mode = 3'($urandom);
      for (int c = 0; c < 3; c++) intvl[4*c +: 4] = 4'($urandom_range(0, 3));
      jit = 1'($urandom);
      en = 1'b1;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 49) == 0) begin
          ch = $urandom_range(0, 2);
          intvl[4*ch +: 4] = 4'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 19) == 0) jit = ~jit;
        en  = ($urandom_range(0, 99) != 0);
        ack = 3'($urandom & $urandom & $urandom);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_gen_mc.md
Name: intr_gen_mc

Overview:
- Parametrised multi-channel interrupt stimulus generator for the kudu/ibex core testbench; successor to the single-interval intr_gen.
- Each channel has its own interval, level or pulse mode, optional LFSR jitter, and ack handshake.
- Counts lost (overrun) interrupts per channel and total interrupt fires, so tests can check interrupt coverage.
- Drives core irq inputs; acks come from the data memory model's interrupt-ack register.

Parameters:
- NumCh, 3, number of interrupt channels (1..8).
- CntW, 16, interval down-counter width (>= 9).
- LfsrSeed, 32'h1234_5678, LFSR reset value (must be nonzero).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low.
- en_i  input  1  global enable.
- intvl_i  input  4*NumCh  per-channel interval code, channel c at [4c+3:4c]; 0 = channel disabled.
- mode_i  input  NumCh  per-channel mode: 0 = level, 1 = pulse.
- jitter_en_i  input  1  add LFSR jitter to reload values.
- ack_i  input  NumCh  per-channel interrupt acknowledge.
- irq_o  output  NumCh  interrupt outputs.
- lost_cnt_o  output  8*NumCh  per-channel saturating overrun count.
- total_fire_cnt_o  output  16  wrapping count of all expiries.

Behaviour:
- Reset (sampled on clk_i edge with rst_ni=0):
  - irq_o=0, lost_cnt_o=0, total_fire_cnt_o=0.
  - All channels IDLE, counters 0, LFSR=LfsrSeed.
- LFSR:
  - 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1).
  - Shifts right every cycle out of reset, regardless of en_i.
- Reload value L for channel c = {intvl_c, 4'b0} + (jitter_en_i ? lfsr[4c+3:4c] : 0).
  - L is zero-extended to CntW; LFSR bits are sampled at the load edge.
- Per-channel FSM states: IDLE, COUNT, ASSERT.
  - IDLE: if en_i && intvl_c != 0, load cnt=L and go to COUNT.
  - COUNT: cnt decrements each cycle. Expiry = (cnt==0) in COUNT or ASSERT.
    - On expiry: cnt reloads to L (interval sampled at that edge).
    - Level mode: go to ASSERT and set irq_o[c].
    - Pulse mode: irq_o[c]=1 for exactly one cycle, stay in COUNT; ack_i ignored.
  - ASSERT (level mode only): counter keeps running.
    - Next irq = expiry | (irq & ~ack).
    - ack without expiry: irq_o[c] clears next cycle, state returns to COUNT.
    - Expiry while irq_o[c]=1 and no ack: lost_cnt[c]+1, saturating at 8'hFF.
    - Expiry and ack on the same edge: irq stays 1, no loss counted, stay in ASSERT.
    - ack while irq_o[c]=0: ignored.
- Timing: irq_o[c] rises exactly L+1 edges after the load edge.
- Disable: en_i=0 or intvl_c becomes 0 forces IDLE on the next edge.
  - irq_o[c] and cnt cleared; lost_cnt and total_fire_cnt held.
- Interval or mode changes during COUNT/ASSERT take effect only at the next reload.
- total_fire_cnt_o += popcount(expiries this cycle), modulo 2^16.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- en=1, ch0 intvl=1, level mode, jitter off, no ack, load at edge E0 -> irq_o[0] rises at E0+17 and stays high; at E0+34 lost_cnt[0]=1; total_fire_cnt=2.
- ch1 intvl=2, pulse mode -> irq_o[1] high for single cycles at load+33, +66, +99; total_fire_cnt increments 1 per pulse; lost_cnt[1]=0 throughout.
- ch0 level, ack asserted one cycle after irq rises -> irq low next cycle, next rise 17 edges after the first rise; with ack coincident with expiry -> irq stays 1, lost_cnt unchanged.
- All 3 channels intvl=1, level, enabled on the same edge -> all irq_o rise together (irq_o=3'b111); total_fire_cnt steps 0 -> 3 in one cycle.
- jitter_en=1, intvl=1 -> each period equals 17 + the LFSR nibble sampled at load (range 17..32); checked against a bench LFSR reference model from LfsrSeed.
- rst_ni=0 for one edge while irq_o[0]=1 and lost_cnt[0]=5 -> irq_o=0, lost_cnt=0, total_fire_cnt=0, LFSR back to seed; en_i=0 mid-count -> irq clears, no further fires.
